prio_arb: RTL and testbench
===========================

# prio_arb

Parametrised, registered N-input priority arbiter: the sequential successor to the team's 8:3 combinational priority encoder. It samples a request vector and selects one winner by fixed priority (highest index wins, as in the 8:3 encoder) or round-robin. The winner is presented as a registered index plus one-hot grant under a valid/ready handshake. It sits between multiple requesters and a single shared downstream consumer (bus port, FIFO write port).

## Interface
Parameters:
- N, 8, number of requesters (2..64)
- W, $clog2(N), index width (derived; do not override)
- MODE, 1, 0 = fixed priority (highest index wins), 1 = round-robin

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  request vector, bit i = requester i
- gnt_ready  in  1  downstream accepts current grant
- gnt_valid  out  1  grant valid
- gnt_idx  out  W  index of granted requester
- gnt_onehot  out  N  one-hot of gnt_idx when gnt_valid, else 0
- lock  in  1  hold grant on current winner (present only with PRIO_ARB_LOCK_EN)

## Operation
- States:
  - IDLE: no grant outstanding.
  - GRANT: gnt_valid=1, outputs stable.
- IDLE -> GRANT when |req: winner is registered. IDLE -> IDLE when req==0.
- GRANT, no handshake (gnt_ready=0):
  - gnt_idx and gnt_onehot are held stable.
  - req changes are ignored, including the granted requester dropping its req.
- GRANT, handshake (gnt_valid & gnt_ready):
  - RR mode: pointer <= (gnt_idx+1) mod N.
  - If |req in the same cycle: re-arbitrate with the updated pointer and stay in GRANT. Back-to-back grants are allowed, one per cycle.
  - Otherwise: go to IDLE.
- Fixed mode: winner = highest set bit of req. The pointer is unused.
- RR mode: winner = first set bit at index >= pointer. If none, the first set bit from index 0 (wrap-around).
- The just-granted requester becomes lowest priority after its handshake.
- Pointer wraps N-1 -> 0. Non-power-of-2 N must never yield an index >= N.

## Timing
- Reset values: gnt_valid=0, gnt_idx=0, gnt_onehot=0, pointer=0, state=IDLE. Reset applies immediately and asynchronously, mid-grant included. The first arbitration occurs on the first clock edge after rst deasserts.
- Latency: req sampled at edge t gives gnt_valid at t+1 (1 cycle).
- Throughput: 1 grant/cycle while gnt_ready=1 and req is nonzero.
- After the last handshake with req==0, gnt_valid is low from the next cycle.
- gnt_onehot == (1<<gnt_idx) whenever gnt_valid. Both are registered, with no combinational path from req.

## Configuration
- PRIO_ARB_LOCK_EN defined:
  - The lock port exists.
  - At a handshake with lock=1 and req[gnt_idx]=1: the same index is re-granted next cycle and the pointer is not advanced.
  - lock=1 with req[gnt_idx]=0: lock is ignored and arbitration proceeds normally.
- PRIO_ARB_LOCK_EN undefined: no lock port, no lock logic. Behaviour is identical to the lock=0 case.

## Structure
- Package prio_arb_pkg holds:
  - MODE_FIXED=0 and MODE_RR=1 constants
  - state enum typedef (ST_IDLE, ST_GRANT)
- Sub-module prio_find_first: combinational, parametrised by N.
  - Returns found flag and index of the highest (fixed) or lowest (RR) set bit.
  - RR mode instantiates it twice: on req masked with bits >= pointer, and on unmasked req for wrap-around.

## Test plan
All with N=8.
- Reset: rst=1, req=8'hFF, gnt_ready=1 -> gnt_valid=0, gnt_idx=0, gnt_onehot=0 throughout. Reset asserted mid-GRANT clears outputs without waiting for a clock edge.
- RR rotation: MODE=1, req=8'b0101_0101 held, gnt_ready=1 -> gnt_idx 0,2,4,6,0,2 on consecutive cycles, gnt_valid constantly 1.
- Fixed priority: MODE=0, req=8'b0110_0000 held -> gnt_idx=6 on every grant. req=8'b0101_0101 -> 6. req=8'b1000_0000 -> 7, gnt_onehot=8'h80.
- Backpressure: grant idx=2 issued, gnt_ready=0 for 3 cycles while req changes to 8'h80 -> gnt_idx stays 2 and gnt_onehot stays 8'h04. On ready, handshake occurs, then idx=7 follows.
- Drain/wrap: MODE=1, pointer at 7, req=8'b0000_0001 -> idx 0 granted. After the handshake with req=0, gnt_valid=0 next cycle.
- Lock (PRIO_ARB_LOCK_EN): req=8'b0000_0011, lock=1, gnt_ready=1 -> idx 0,0,0. Then lock=0 -> idx 1 next, then 0.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared constants and types for the prio_arb priority arbiter.
//   MODE_FIXED / MODE_RR : arbitration mode selectors for prio_arb.MODE
//   state_t              : grant FSM state encoding
package prio_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/prio_find_first.sv
// prio_find_first: combinational search for a set bit in a vector.
//   vec   in  N  vector to search
//   found out 1  vec has at least one set bit
//   idx   out W  index of the highest (HIGHEST=1) or lowest (HIGHEST=0) set bit,
//                0 when nothing is set
module prio_find_first #(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter bit HIGHEST = 1'b0
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // The scan direction is chosen so the last match written is the one wanted.
  always_comb begin
    found = |vec;
    idx   = '0;
    if (HIGHEST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_arb.sv
// prio_arb: registered N-input priority arbiter with valid/ready grant output.
// Fixed priority (highest index wins) or round-robin (first set bit at or after
// the pointer, wrapping to index 0). The just-granted requester becomes lowest
// priority after its handshake in round-robin mode.
//   clk        in  1  rising-edge clock
//   rst        in  1  asynchronous active-high reset
//   req        in  N  request vector
//   lock       in  1  re-grant the current winner at handshake (only with
//                     PRIO_ARB_LOCK_EN defined)
//   gnt_ready  in  1  downstream accepts the current grant
//   gnt_valid  out 1  grant valid
//   gnt_idx    out W  granted requester index
//   gnt_onehot out N  one-hot of gnt_idx while gnt_valid, else 0
// Optional feature macro: PRIO_ARB_LOCK_EN.
module prio_arb
  import prio_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_RR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
`ifdef PRIO_ARB_LOCK_EN
  input  logic         lock,
`endif
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  state_t         state, state_nxt;
  logic [W-1:0]   ptr, ptr_inc, arb_ptr;
  logic [W-1:0]   win_idx;
  logic           win_found;
  logic           lock_hit;
  logic           hs_adv;
  logic           load;

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef PRIO_ARB_LOCK_EN
  // Lock only holds while the locked requester still asks for the resource.
  assign lock_hit = lock & req[gnt_idx];
`else
  assign lock_hit = 1'b0;
`endif

  // Explicit wrap so non-power-of-2 N never produces an index >= N.
  assign ptr_inc = (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // A handshake that is not locked retires the grant and moves the pointer;
  // arbitration in that same cycle already uses the advanced pointer.
  assign hs_adv  = (state == ST_GRANT) && gnt_ready && !lock_hit;
  assign arb_ptr = ((MODE == MODE_RR) && hs_adv) ? ptr_inc : ptr;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [N-1:0] mask_req;
      logic         m_found, a_found;
      logic [W-1:0] m_idx, a_idx;

      always_comb begin
        mask_req = '0;
        for (int i = 0; i < N; i++) begin
          mask_req[i] = req[i] && (W'(i) >= arb_ptr);
        end
      end

      prio_find_first #(.N(N), .W(W), .HIGHEST(1'b0)) u_find_masked (
        .vec   (mask_req),
        .found (m_found),
        .idx   (m_idx)
      );

      prio_find_first #(.N(N), .W(W), .HIGHEST(1'b0)) u_find_wrap (
        .vec   (req),
        .found (a_found),
        .idx   (a_idx)
      );

      assign win_found = a_found;
      assign win_idx   = m_found ? m_idx : a_idx;
    end else begin : g_fixed
      prio_find_first #(.N(N), .W(W), .HIGHEST(1'b1)) u_find_high (
        .vec   (req),
        .found (win_found),
        .idx   (win_idx)
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt = ST_GRANT;
          load      = 1'b1;
        end
      end
      ST_GRANT: begin
        // Locked handshake keeps state, index and pointer untouched.
        if (hs_adv) begin
          if (win_found) load = 1'b1;
          else           state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> output register: grant index/one-hot and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= arb_ptr;
      if (load) begin
        gnt_idx    <= win_idx;
        gnt_onehot <= to_onehot(win_idx);
      end else if (state_nxt == ST_IDLE) begin
        gnt_onehot <= '0;
      end
    end
  end

  assign gnt_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_prio_arb.sv
module tb_prio_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
`ifdef PRIO_ARB_LOCK_EN
  logic       lock;
`endif

  logic       rr_valid, fx_valid;
  logic [2:0] rr_idx, fx_idx;
  logic [7:0] rr_onehot, fx_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_arb #(.N(8), .MODE(1)) dut_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef PRIO_ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt_ready  (gnt_ready),
    .gnt_valid  (rr_valid),
    .gnt_idx    (rr_idx),
    .gnt_onehot (rr_onehot)
  );

  prio_arb #(.N(8), .MODE(0)) dut_fx (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef PRIO_ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt_ready  (gnt_ready),
    .gnt_valid  (fx_valid),
    .gnt_idx    (fx_idx),
    .gnt_onehot (fx_onehot)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       rr_v;
    logic [2:0] rr_i;
    logic       fx_v;
    logic [2:0] fx_i;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic rv, input logic [2:0] ri,
                          input logic fv, input logic [2:0] fi, input logic idx_always);
    logic [7:0] roh, foh;
    roh = 8'h00;
    foh = 8'h00;
    if (rv) roh[ri] = 1'b1;
    if (fv) foh[fi] = 1'b1;
    chk({tag, " rr_valid"},  32'(rr_valid),  32'(rv));
    chk({tag, " rr_onehot"}, 32'(rr_onehot), 32'(roh));
    if (rv || idx_always) chk({tag, " rr_idx"}, 32'(rr_idx), 32'(ri));
    chk({tag, " fx_valid"},  32'(fx_valid),  32'(fv));
    chk({tag, " fx_onehot"}, 32'(fx_onehot), 32'(foh));
    if (fv || idx_always) chk({tag, " fx_idx"}, 32'(fx_idx), 32'(fi));
  endtask

  initial begin
    rst       = 1'b1;
    req       = 8'h00;
    gnt_ready = 1'b0;
`ifdef PRIO_ARB_LOCK_EN
    lock      = 1'b0;
`endif

    //          rst  req     rdy  rr_v rr_i fx_v fx_i
    vt[0]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0}; // reset holds outputs
    vt[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0};
    vt[2]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd0, 1'b1, 3'd6}; // first arbitration
    vt[3]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd2, 1'b1, 3'd6}; // rotation
    vt[4]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd4, 1'b1, 3'd6};
    vt[5]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd6, 1'b1, 3'd6};
    vt[6]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd0, 1'b1, 3'd6}; // wrap
    vt[7]  = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd2, 1'b1, 3'd6};
    vt[8]  = '{1'b0, 8'h60, 1'b1, 1'b1, 3'd5, 1'b1, 3'd6};
    vt[9]  = '{1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 1'b1, 3'd7};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0}; // drain to idle
    vt[11] = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2}; // grant 2
    vt[12] = '{1'b0, 8'h80, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2}; // backpressure hold
    vt[13] = '{1'b0, 8'h80, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
    vt[14] = '{1'b0, 8'h80, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
    vt[15] = '{1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 1'b1, 3'd7}; // handshake then 7
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0};
    vt[17] = '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6}; // pointer goes to 7 next
    vt[18] = '{1'b0, 8'h01, 1'b1, 1'b1, 3'd0, 1'b1, 3'd0}; // wrap from 7 to 0
    vt[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0}; // valid drops next cycle
    vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0};

    for (int i = 0; i < 21; i++) begin
      rst       = vt[i].rst;
      req       = vt[i].req;
      gnt_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk_both($sformatf("vec%0d", i), vt[i].rr_v, vt[i].rr_i, vt[i].fx_v, vt[i].fx_i,
               vt[i].rst);
    end

    // Asynchronous reset in the middle of a grant (RR pointer is 1 here).
    req       = 8'hFF;
    gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_both("pre_async", 1'b1, 3'd1, 1'b1, 3'd7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_both("async_rst", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_both("post_rst", 1'b1, 3'd0, 1'b1, 3'd7, 1'b0);

`ifdef PRIO_ARB_LOCK_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req       = 8'h03;
    lock      = 1'b1;
    gnt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_both($sformatf("lock%0d", k), 1'b1, 3'd0, 1'b1, 3'd1, 1'b0);
    end
    lock = 1'b0;
    @(posedge clk);
    #1;
    chk_both("unlock0", 1'b1, 3'd1, 1'b1, 3'd1, 1'b0);
    @(posedge clk);
    #1;
    chk_both("unlock1", 1'b1, 3'd0, 1'b1, 3'd1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
